piezo_tone_detector: RTL and testbench
======================================

// Module: piezo_tone_detector
// PURPOSE
//  Receive end of the piezo tone path: measures the period of an incoming square wave (tone_in) in clk cycles.
//  Classifies it to one of eight notes, C2..C3, and reports the note as an 8-bit one-hot code, the same code the button keypad uses.
//  Sits beside the piezo tone generator for loopback self-test, or behind an external comparator/microphone front end.
// PARAMETERS
//  TOL        16     accepted +/- deviation (clk cycles) from a nominal full period
//  STABLE_CNT 2      consecutive matching periods required before a note is reported (1..15)
//  TIMEOUT    8191   cycles without a rising edge -> silence; also the counter saturation value
//  CNT_W      13     width of period counter/measurement
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous reset, active-high
//  tone_in      in   1      asynchronous square-wave input
//  note         out  8      one-hot note: bit0=C2 ... bit7=C3; 0 = silence/unknown
//  note_valid   out  1      1 while note != 0
//  note_strobe  out  1      1-cycle pulse whenever note changes, including to 0
//  period       out  CNT_W  last measured full period in clk cycles (saturates at TIMEOUT)
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): all outputs 0, counter 0, match count 0, candidate 0, FSM -> IDLE, sync FFs 0.
//  Input path: 2-FF synchronizer, then a rising-edge detect (sync2 & ~sync3).
//   - edge_det asserts 3 clk cycles after tone_in rises.
//  Nominal full periods (cycles), matching the generator's toggle every limit/2+1 cycles:
//   C2 3832, D2 3402, E2 3040, F2 2866, G2 2552, A2 2274, B2 2030, C3 1914.
//  Classifier (combinational): a period matches note k iff |period - NOM_k| <= TOL.
//   - No match -> class 0.
//   - With TOL < 58 the windows are disjoint; the lowest index wins if the windows overlap.
//  FSM states:
//   IDLE: counter held at 0. On edge_det: -> MEAS, counter <= 1.
//   MEAS: counter += 1 each cycle.
//    - On edge_det: period <= counter; evaluate class; counter <= 1.
//    - counter reaching TIMEOUT with no edge: -> IDLE; period <= TIMEOUT; class treated as 0.
//  Qualification, evaluated at each measured edge:
//   - class == candidate && class != 0: match count += 1, saturating at STABLE_CNT.
//   - otherwise: candidate <= class, match count <= 1.
//   - Update rule: when match count reaches STABLE_CNT with candidate != note, note <= candidate and note_strobe = 1.
//  Loss of tone: on the TIMEOUT transition, or on any measured period with class 0:
//   - note <= 0, with note_strobe pulsed if note was nonzero.
//   - match count <= 0, candidate <= 0.
//  Latency:
//   - note updates on the cycle after the edge_det that completes the STABLE_CNT-th matching period.
//   - With STABLE_CNT=2 that is the third detected rising edge, since the first edge only arms measurement.
//  Simultaneous events: edge_det and TIMEOUT in the same cycle -> the edge wins (measured period = TIMEOUT, class 0).
//  Mid-run note change: an old note stays asserted until the new note qualifies.
//   - Exception: an unclassifiable period in between clears it to 0.
//  rst mid-measurement: all state is discarded, and the next edge only re-arms measurement.
//  note_valid = |note, registered identically to note.
// STRUCTURE
//  Shared include piezo_notes.vh: NOM_C2..NOM_C3 period constants and one-hot note codes (shared with the generator).
//  Sub-module tone_classifier: combinational period[CNT_W-1:0] -> one-hot class[7:0] using TOL.
//  Synchronizer, edge detect, counter, FSM and qualification stay in this module.
// TESTING
//  1 Square wave, period 3832 (1916 hi / 1916 lo).
//    -> note=8'h01 and a single note_strobe one cycle after the 3rd detected edge; period=3832.
//  2 Switch from 2030 (B2) to 1914 (C3).
//    -> note stays 8'h40 until 2 C3 periods are measured, then 8'h80 with one strobe.
//  3 Period 2600, which is between G2 and F2.
//    -> note stays 0, no strobe; period=2600.
//  4 Lock A2 (2274), then hold tone_in low.
//    -> 8191 cycles after the last edge: note=0, strobe pulse, period=8191, FSM IDLE.
//  5 Period 3040+TOL (3056) -> E2 lock; period 3057 -> no match, note=0.
//  6 Assert rst during MEAS while C2 is locked.
//    -> next cycle all outputs 0; C2 relocks only after 3 further edges.

Source files
------------

// File: rtl/piezo_tone_detector_pkg.sv
// Shared note definitions for the piezo tone path: nominal full periods,
// one-hot note codes matching the button keypad, and the detector FSM states.
package piezo_tone_detector_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_MEAS
   } det_state_t;

   localparam int NUM_NOTES = 8;

   // Nominal full periods in clk cycles, as produced by the tone generator
   localparam int NOM_C2 = 3832;
   localparam int NOM_D2 = 3402;
   localparam int NOM_E2 = 3040;
   localparam int NOM_F2 = 2866;
   localparam int NOM_G2 = 2552;
   localparam int NOM_A2 = 2274;
   localparam int NOM_B2 = 2030;
   localparam int NOM_C3 = 1914;

   // Indexed by note number, bit position in the one-hot code
   localparam int NOM_PERIOD [NUM_NOTES] = '{
      NOM_C2, NOM_D2, NOM_E2, NOM_F2, NOM_G2, NOM_A2, NOM_B2, NOM_C3
   };

   // One-hot note codes, identical to the keypad encoding
   localparam logic [7:0] NOTE_NONE = 8'h00;
   localparam logic [7:0] NOTE_C2   = 8'h01;
   localparam logic [7:0] NOTE_D2   = 8'h02;
   localparam logic [7:0] NOTE_E2   = 8'h04;
   localparam logic [7:0] NOTE_F2   = 8'h08;
   localparam logic [7:0] NOTE_G2   = 8'h10;
   localparam logic [7:0] NOTE_A2   = 8'h20;
   localparam logic [7:0] NOTE_B2   = 8'h40;
   localparam logic [7:0] NOTE_C3   = 8'h80;

   // True when a measured period lies within +/- tol of a nominal period
   function automatic logic in_window(input int meas, input int nom, input int tol);
      return (meas >= (nom - tol)) && (meas <= (nom + tol));
   endfunction

endpackage

// File: rtl/piezo_tone_detector_classifier.sv
// Combinational period classifier: maps a measured full period onto the
// one-hot note whose tolerance window contains it, or 0 when none does.
module tone_classifier
   import piezo_tone_detector_pkg::*;
#(
   parameter int CNT_W = 13,
   parameter int TOL   = 16
) (
   input  logic [CNT_W-1:0] period,
   output logic [7:0]       note_class
);

   logic [31:0] period_ext;

   assign period_ext = 32'(period);

   // Scan from the highest note down so that the lowest matching index is
   // the last one written, which resolves any overlap between windows.
   always_comb begin
      note_class = NOTE_NONE;
      for (int k = NUM_NOTES - 1; k >= 0; k--) begin
         if (in_window(int'(period_ext), NOM_PERIOD[k], TOL)) begin
            note_class = NOTE_C2 << k;
         end
      end
   end

endmodule

// File: rtl/piezo_tone_detector.sv
// Receive end of the piezo tone path. Synchronizes the incoming square wave,
// measures the time between rising edges, classifies each period to a note
// and reports a note only once it has been seen on enough consecutive periods.
module piezo_tone_detector
   import piezo_tone_detector_pkg::*;
#(
   parameter int TOL        = 16,
   parameter int STABLE_CNT = 2,
   parameter int TIMEOUT    = 8191,
   parameter int CNT_W      = 13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tone_in,
   output logic [7:0]       note,
   output logic             note_valid,
   output logic             note_strobe,
   output logic [CNT_W-1:0] period
);

   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [3:0]       STABLE_V  = 4'(STABLE_CNT);

   logic             sync1;
   logic             sync2;
   logic             sync3;
   logic             edge_det;

   det_state_t       state;
   det_state_t       state_next;

   logic [CNT_W-1:0] counter;
   logic             timeout_hit;

   logic             arm;
   logic             meas_edge;
   logic             meas_timeout;
   logic             count_run;

   logic [7:0]       note_class;
   logic [7:0]       candidate;
   logic [3:0]       match_cnt;

   logic             lose_tone;
   logic [7:0]       cand_next;
   logic [3:0]       match_next;
   logic [7:0]       note_next;
   logic             strobe_next;

   // Two flops tame the asynchronous input; the third holds the previous
   // synchronized level so a rising edge can be spotted.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= tone_in;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign edge_det    = sync2 & ~sync3;
   assign timeout_hit = (counter == TIMEOUT_V);

   // State register for the measurement FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: the first edge arms measurement, a silent stretch as
   // long as TIMEOUT drops back to idle. An edge arriving in the timeout
   // cycle keeps us measuring.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (edge_det) begin
               state_next = ST_MEAS;
            end
         end
         ST_MEAS: begin
            if (!edge_det && timeout_hit) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM outputs: decode which datapath action happens this cycle
   always_comb begin
      arm          = 1'b0;
      meas_edge    = 1'b0;
      meas_timeout = 1'b0;
      count_run    = 1'b0;
      case (state)
         ST_IDLE: begin
            arm = edge_det;
         end
         ST_MEAS: begin
            meas_edge    = edge_det;
            meas_timeout = !edge_det && timeout_hit;
            count_run    = !edge_det && !timeout_hit;
         end
         default: ;
      endcase
   end

   // Period counter: restarts at 1 on every edge so that the value seen at the
   // next edge equals the full period in clk cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         counter <= '0;
      end else if (arm || meas_edge) begin
         counter <= CNT_ONE;
      end else if (meas_timeout) begin
         counter <= '0;
      end else if (count_run) begin
         counter <= counter + CNT_ONE;
      end
   end

   // Latch the last full period; silence reports the saturation value.
   always_ff @(posedge clk) begin
      if (rst) begin
         period <= '0;
      end else if (meas_edge) begin
         period <= counter;
      end else if (meas_timeout) begin
         period <= TIMEOUT_V;
      end
   end

   tone_classifier #(
      .CNT_W (CNT_W),
      .TOL   (TOL)
   ) u_classifier (
      .period     (counter),
      .note_class (note_class)
   );

   // Qualification: count consecutive periods of the same class, and promote
   // the candidate to the reported note once it has been stable long enough.
   // Silence or an unrecognised period clears everything straight away.
   always_comb begin
      lose_tone   = meas_timeout || (meas_edge && (note_class == NOTE_NONE));
      cand_next   = candidate;
      match_next  = match_cnt;
      note_next   = note;
      strobe_next = 1'b0;

      if (lose_tone) begin
         cand_next   = NOTE_NONE;
         match_next  = 4'd0;
         note_next   = NOTE_NONE;
         strobe_next = (note != NOTE_NONE);
      end else if (meas_edge) begin
         if (note_class == candidate) begin
            match_next = (match_cnt >= STABLE_V) ? STABLE_V : (match_cnt + 4'd1);
         end else begin
            cand_next  = note_class;
            match_next = 4'd1;
         end
         if ((match_next >= STABLE_V) && (cand_next != note)) begin
            note_next   = cand_next;
            strobe_next = 1'b1;
         end
      end
   end

   // Qualification and output registers; note_valid tracks note exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         candidate   <= NOTE_NONE;
         match_cnt   <= 4'd0;
         note        <= NOTE_NONE;
         note_valid  <= 1'b0;
         note_strobe <= 1'b0;
      end else begin
         candidate   <= cand_next;
         match_cnt   <= match_next;
         note        <= note_next;
         note_valid  <= |note_next;
         note_strobe <= strobe_next;
      end
   end

endmodule

// File: tb/tb_piezo_tone_detector.sv
// Directed self-checking bench for the piezo tone detector: locks, note
// changes, out-of-window periods, silence timeout, tolerance edge and reset.
module tb_piezo_tone_detector;

   logic        clk;
   logic        rst;
   logic        tone_in;
   logic [7:0]  note;
   logic        note_valid;
   logic        note_strobe;
   logic [12:0] period;

   int checks;
   int errors;
   int strobe_count;
   int base;

   piezo_tone_detector dut (
      .clk         (clk),
      .rst         (rst),
      .tone_in     (tone_in),
      .note        (note),
      .note_valid  (note_valid),
      .note_strobe (note_strobe),
      .period      (period)
   );

   // 10 ns system clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count every cycle the strobe is high, sampled mid-cycle
   always @(negedge clk) begin
      if (note_strobe) strobe_count++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One full period of the square wave, rising edge first
   task automatic applyStimulus(input int hi, input int lo);
      tone_in = 1'b1;
      step(hi);
      tone_in = 1'b0;
      step(lo);
   endtask

   task automatic doReset();
      rst     = 1'b1;
      tone_in = 1'b0;
      step(2);
      rst     = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      strobe_count = 0;
      rst          = 1'b1;
      tone_in      = 1'b0;
      step(3);
      checkOutput("rst_note",   32'(note), 32'h00);
      checkOutput("rst_valid",  32'(note_valid), 32'd0);
      checkOutput("rst_strobe", 32'(note_strobe), 32'd0);
      checkOutput("rst_period", 32'(period), 32'd0);
      rst = 1'b0;
      step(1);

      // C2 lock with exact latency around the third rising edge
      $display("[TB] C2 lock");
      base = strobe_count;
      applyStimulus(1916, 1916);
      applyStimulus(1916, 1916);
      tone_in = 1'b1;
      step(2);
      checkOutput("t1_early_note", 32'(note), 32'h00);
      step(1);
      checkOutput("t1_note",   32'(note), 32'h01);
      checkOutput("t1_valid",  32'(note_valid), 32'd1);
      checkOutput("t1_strobe", 32'(note_strobe), 32'd1);
      step(1);
      checkOutput("t1_strobe_end", 32'(note_strobe), 32'd0);
      step(1912);
      tone_in = 1'b0;
      step(1916);
      checkOutput("t1_period",  32'(period), 32'd3832);
      checkOutput("t1_strobes", 32'(strobe_count - base), 32'd1);

      // Reset in the middle of a measurement while C2 is locked
      $display("[TB] reset mid-measurement");
      tone_in = 1'b1;
      step(1916);
      tone_in = 1'b0;
      step(500);
      rst = 1'b1;
      step(1);
      checkOutput("t6_rst_note",   32'(note), 32'h00);
      checkOutput("t6_rst_valid",  32'(note_valid), 32'd0);
      checkOutput("t6_rst_strobe", 32'(note_strobe), 32'd0);
      checkOutput("t6_rst_period", 32'(period), 32'd0);
      rst = 1'b0;
      step(1415);
      base = strobe_count;
      applyStimulus(1916, 1916);
      applyStimulus(1916, 1916);
      checkOutput("t6_not_yet",  32'(note), 32'h00);
      checkOutput("t6_period",   32'(period), 32'd3832);
      tone_in = 1'b1;
      step(3);
      checkOutput("t6_relock",   32'(note), 32'h01);
      step(1);
      checkOutput("t6_strobes",  32'(strobe_count - base), 32'd1);

      // B2 lock, then switch to C3
      $display("[TB] B2 to C3");
      doReset();
      base = strobe_count;
      for (int i = 0; i < 3; i++) applyStimulus(1015, 1015);
      checkOutput("t2_b2_lock", 32'(note), 32'h40);
      applyStimulus(957, 957);
      applyStimulus(957, 957);
      checkOutput("t2_hold",         32'(note), 32'h40);
      checkOutput("t2_hold_strobes", 32'(strobe_count - base), 32'd1);
      applyStimulus(957, 957);
      checkOutput("t2_c3_lock", 32'(note), 32'h80);
      checkOutput("t2_period",  32'(period), 32'd1914);
      checkOutput("t2_strobes", 32'(strobe_count - base), 32'd2);

      // Period between G2 and F2 windows
      $display("[TB] unclassifiable period");
      doReset();
      base = strobe_count;
      for (int i = 0; i < 3; i++) applyStimulus(1300, 1300);
      checkOutput("t3_note",    32'(note), 32'h00);
      checkOutput("t3_valid",   32'(note_valid), 32'd0);
      checkOutput("t3_period",  32'(period), 32'd2600);
      checkOutput("t3_strobes", 32'(strobe_count - base), 32'd0);

      // A2 lock, then silence until timeout
      $display("[TB] A2 then silence");
      doReset();
      base = strobe_count;
      for (int i = 0; i < 3; i++) applyStimulus(1137, 1137);
      checkOutput("t4_lock", 32'(note), 32'h20);
      step(5919);
      checkOutput("t4_before_timeout", 32'(note), 32'h20);
      step(1);
      checkOutput("t4_to_note",   32'(note), 32'h00);
      checkOutput("t4_to_valid",  32'(note_valid), 32'd0);
      checkOutput("t4_to_strobe", 32'(note_strobe), 32'd1);
      checkOutput("t4_to_period", 32'(period), 32'd8191);
      tone_in = 1'b1;
      step(4);
      checkOutput("t4_arm_only", 32'(period), 32'd8191);
      step(1);
      checkOutput("t4_strobes",  32'(strobe_count - base), 32'd2);

      // Tolerance boundary around E2
      $display("[TB] E2 tolerance edge");
      doReset();
      base = strobe_count;
      for (int i = 0; i < 3; i++) applyStimulus(1528, 1528);
      checkOutput("t5_lock",   32'(note), 32'h04);
      checkOutput("t5_period", 32'(period), 32'd3056);
      applyStimulus(1529, 1528);
      applyStimulus(1529, 1528);
      checkOutput("t5_out_note",  32'(note), 32'h00);
      checkOutput("t5_out_valid", 32'(note_valid), 32'd0);
      checkOutput("t5_period2",   32'(period), 32'd3057);
      checkOutput("t5_strobes",   32'(strobe_count - base), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
